// File: rtl/ex_mem_stage.sv
// ex_mem_stage: MIPS execute stage (forwarding, ALU, branch target) feeding the EX/MEM register; 1 falling edge latency.
// stall_ex freezes the front end and bubbles EX/MEM while the shift-add multiplier runs (built only when EX_MUL_EN is defined).
module ex_mem_stage #(
   parameter int MUL_CYCLES = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] nextpc,
   input  logic [31:0] reg_file_out_data1,
   input  logic [31:0] reg_file_out_data2,
   input  logic [31:0] sgn_ext_imm_out,
   input  logic        branch_out_id_ex,
   input  logic        reg_write_out_id_ex,
   input  logic        mem_to_reg_out_id_ex,
   input  logic        mem_write_out_id_ex,
   input  logic        mem_read_out_id_ex,
   input  logic        alu_src_out_id_ex,
   input  logic        reg_dst_id_ex,
   input  logic [1:0]  alu_op_out_id_ex,
   input  logic [4:0]  inst_read_reg_addr1_out_id_ex,
   input  logic [4:0]  inst_read_reg_addr2_out_id_ex,
   input  logic [4:0]  rd_out_id_ex,
   input  logic [4:0]  rd_out_wb,
   input  logic        reg_write_out_wb,
   input  logic [31:0] reg_wr_data,
   output logic [31:0] alu_result_out_ex_mem,
   output logic [31:0] wr_data_out_ex_mem,
   output logic [31:0] branch_target_out_ex_mem,
   output logic [4:0]  rd_out_ex_mem,
   output logic        zero_out_ex_mem,
   output logic        branch_out_ex_mem,
   output logic        reg_write_out_ex_mem,
   output logic        mem_to_reg_out_ex_mem,
   output logic        mem_write_out_ex_mem,
   output logic        mem_read_out_ex_mem,
   output logic        stall_ex
);

   typedef struct packed {
      logic branch;
      logic reg_write;
      logic mem_to_reg;
      logic mem_write;
      logic mem_read;
   } ctrl_t;

   ctrl_t       w_ctrl_id;
   logic        w_exm_fwd_ok;
   logic        w_wb_fwd_ok;
   logic [31:0] w_fwd_a;
   logic [31:0] w_fwd_rt;
   logic [31:0] w_op_b;
   logic [5:0]  w_funct;
   logic [4:0]  w_shamt;
   logic [31:0] w_alu_res;
   logic [4:0]  w_rd_sel;
   logic [31:0] w_target;

   logic [31:0] w_out_result;
   logic        w_out_zero;
   logic [4:0]  w_out_rd;
   logic [31:0] w_out_wr_data;
   logic [31:0] w_out_target;
   ctrl_t       w_out_ctrl;

   logic [31:0] r_alu_result;
   logic [31:0] r_wr_data;
   logic [31:0] r_target;
   logic [4:0]  r_rd;
   logic        r_zero;
   ctrl_t       r_ctrl;

   assign w_ctrl_id = {branch_out_id_ex, reg_write_out_id_ex, mem_to_reg_out_id_ex,
                       mem_write_out_id_ex, mem_read_out_id_ex};

   // A load in EX/MEM has no data yet; the hazard unit stalls that case, so it is never a forwarding source.
   assign w_exm_fwd_ok = reg_write_out_ex_mem && (rd_out_ex_mem != 5'd0) && !mem_read_out_ex_mem;
   assign w_wb_fwd_ok  = reg_write_out_wb && (rd_out_wb != 5'd0);

   always_comb begin
      w_fwd_a = reg_file_out_data1;
      if (w_exm_fwd_ok && (rd_out_ex_mem == inst_read_reg_addr1_out_id_ex))
         w_fwd_a = alu_result_out_ex_mem;
      else if (w_wb_fwd_ok && (rd_out_wb == inst_read_reg_addr1_out_id_ex))
         w_fwd_a = reg_wr_data;
   end

   always_comb begin
      w_fwd_rt = reg_file_out_data2;
      if (w_exm_fwd_ok && (rd_out_ex_mem == inst_read_reg_addr2_out_id_ex))
         w_fwd_rt = alu_result_out_ex_mem;
      else if (w_wb_fwd_ok && (rd_out_wb == inst_read_reg_addr2_out_id_ex))
         w_fwd_rt = reg_wr_data;
   end

   assign w_op_b   = alu_src_out_id_ex ? sgn_ext_imm_out : w_fwd_rt;
   assign w_funct  = sgn_ext_imm_out[5:0];
   assign w_shamt  = sgn_ext_imm_out[10:6];
   assign w_rd_sel = reg_dst_id_ex ? rd_out_id_ex : inst_read_reg_addr2_out_id_ex;
   assign w_target = nextpc + {sgn_ext_imm_out[29:0], 2'b00};

   always_comb begin
      w_alu_res = 32'd0;
      case (alu_op_out_id_ex)
         2'b00: w_alu_res = w_fwd_a + w_op_b;
         2'b01: w_alu_res = w_fwd_a - w_op_b;
         2'b11: w_alu_res = w_fwd_a | {16'd0, sgn_ext_imm_out[15:0]};
         default: begin
            // Funct 0x18 lands in the default here; the multiplier supplies its result separately.
            case (w_funct)
               6'h20:   w_alu_res = w_fwd_a + w_op_b;
               6'h22:   w_alu_res = w_fwd_a - w_op_b;
               6'h24:   w_alu_res = w_fwd_a & w_op_b;
               6'h25:   w_alu_res = w_fwd_a | w_op_b;
               6'h2A:   w_alu_res = {31'd0, ($signed(w_fwd_a) < $signed(w_op_b))};
               6'h00:   w_alu_res = w_op_b << w_shamt;
               default: w_alu_res = 32'd0;
            endcase
         end
      endcase
   end

`ifdef EX_MUL_EN
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } mul_state_t;

   localparam int              CNT_W    = $clog2(MUL_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

   mul_state_t       r_state;
   mul_state_t       w_state_nxt;
   logic             w_is_mul;
   logic             w_mul_start;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_mul_a;
   logic [31:0]      r_mul_b;
   logic [31:0]      r_mul_acc;
   logic [31:0]      r_mul_wr_data;
   logic [31:0]      r_mul_target;
   logic [4:0]       r_mul_rd;
   ctrl_t            r_mul_ctrl;

   assign w_is_mul    = (alu_op_out_id_ex == 2'b10) && (w_funct == 6'h18);
   assign w_mul_start = (r_state == S_IDLE) && w_is_mul;
   // DONE releases the stall so the commit edge also advances the front end.
   assign stall_ex    = w_is_mul && (r_state != S_DONE);

   always_ff @(negedge clk or negedge reset) begin
      if (!reset)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_is_mul) w_state_nxt = S_BUSY;
         S_BUSY:  if (r_cnt == CNT_LAST) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt         <= '0;
         r_mul_a       <= '0;
         r_mul_b       <= '0;
         r_mul_acc     <= '0;
         r_mul_wr_data <= '0;
         r_mul_target  <= '0;
         r_mul_rd      <= '0;
         r_mul_ctrl    <= '0;
      end else if (w_mul_start) begin
         r_cnt         <= '0;
         r_mul_a       <= w_fwd_a;
         r_mul_b       <= w_op_b;
         r_mul_acc     <= '0;
         r_mul_wr_data <= w_fwd_rt;
         r_mul_target  <= w_target;
         r_mul_rd      <= w_rd_sel;
         r_mul_ctrl    <= w_ctrl_id;
      end else if (r_state == S_BUSY) begin
         if (r_mul_b[0])
            r_mul_acc <= r_mul_acc + r_mul_a;
         r_mul_a <= r_mul_a << 1;
         r_mul_b <= r_mul_b >> 1;
         r_cnt   <= r_cnt + 1'b1;
      end
   end

   always_comb begin
      w_out_result  = w_alu_res;
      w_out_zero    = (w_alu_res == 32'd0);
      w_out_rd      = w_rd_sel;
      w_out_wr_data = w_fwd_rt;
      w_out_target  = w_target;
      w_out_ctrl    = w_ctrl_id;
      if (r_state == S_DONE) begin
         w_out_result  = r_mul_acc;
         w_out_zero    = (r_mul_acc == 32'd0);
         w_out_rd      = r_mul_rd;
         w_out_wr_data = r_mul_wr_data;
         w_out_target  = r_mul_target;
         w_out_ctrl    = r_mul_ctrl;
      end
   end
`else
   assign stall_ex      = 1'b0;
   assign w_out_result  = w_alu_res;
   assign w_out_zero    = (w_alu_res == 32'd0);
   assign w_out_rd      = w_rd_sel;
   assign w_out_wr_data = w_fwd_rt;
   assign w_out_target  = w_target;
   assign w_out_ctrl    = w_ctrl_id;
`endif

   // Bubble: controls cleared, data fields simply hold.
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         r_alu_result <= '0;
         r_wr_data    <= '0;
         r_target     <= '0;
         r_rd         <= '0;
         r_zero       <= 1'b0;
         r_ctrl       <= '0;
      end else if (stall_ex) begin
         r_ctrl <= '0;
      end else begin
         r_alu_result <= w_out_result;
         r_wr_data    <= w_out_wr_data;
         r_target     <= w_out_target;
         r_rd         <= w_out_rd;
         r_zero       <= w_out_zero;
         r_ctrl       <= w_out_ctrl;
      end
   end

   assign alu_result_out_ex_mem    = r_alu_result;
   assign wr_data_out_ex_mem       = r_wr_data;
   assign branch_target_out_ex_mem = r_target;
   assign rd_out_ex_mem            = r_rd;
   assign zero_out_ex_mem          = r_zero;
   assign branch_out_ex_mem        = r_ctrl.branch;
   assign reg_write_out_ex_mem     = r_ctrl.reg_write;
   assign mem_to_reg_out_ex_mem    = r_ctrl.mem_to_reg;
   assign mem_write_out_ex_mem     = r_ctrl.mem_write;
   assign mem_read_out_ex_mem      = r_ctrl.mem_read;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed vector table, randomized instructions against a reference model,
// reset and multiplier sequences (multiplier sequences only when EX_MUL_EN is defined).
`timescale 1ns/1ps
module tb_ex_mem_stage;
   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] nextpc, d1, d2, imm;
   logic        branch_i, reg_write_i, mem_to_reg_i, mem_write_i, mem_read_i, alu_src_i, reg_dst_i;
   logic [1:0]  alu_op_i;
   logic [4:0]  rs_i, rt_i, rd_i, rd_wb;
   logic        reg_write_wb;
   logic [31:0] reg_wr_data;
   logic [31:0] alu_result, wr_data, target;
   logic [4:0]  rd_o;
   logic        zero_o, branch_o, reg_write_o, mem_to_reg_o, mem_write_o, mem_read_o, stall_ex;

   always #5 clk = ~clk;

   ex_mem_stage dut (
      .clk(clk), .reset(reset), .nextpc(nextpc),
      .reg_file_out_data1(d1), .reg_file_out_data2(d2), .sgn_ext_imm_out(imm),
      .branch_out_id_ex(branch_i), .reg_write_out_id_ex(reg_write_i),
      .mem_to_reg_out_id_ex(mem_to_reg_i), .mem_write_out_id_ex(mem_write_i),
      .mem_read_out_id_ex(mem_read_i), .alu_src_out_id_ex(alu_src_i), .reg_dst_id_ex(reg_dst_i),
      .alu_op_out_id_ex(alu_op_i), .inst_read_reg_addr1_out_id_ex(rs_i),
      .inst_read_reg_addr2_out_id_ex(rt_i), .rd_out_id_ex(rd_i),
      .rd_out_wb(rd_wb), .reg_write_out_wb(reg_write_wb), .reg_wr_data(reg_wr_data),
      .alu_result_out_ex_mem(alu_result), .wr_data_out_ex_mem(wr_data),
      .branch_target_out_ex_mem(target), .rd_out_ex_mem(rd_o), .zero_out_ex_mem(zero_o),
      .branch_out_ex_mem(branch_o), .reg_write_out_ex_mem(reg_write_o),
      .mem_to_reg_out_ex_mem(mem_to_reg_o), .mem_write_out_ex_mem(mem_write_o),
      .mem_read_out_ex_mem(mem_read_o), .stall_ex(stall_ex)
   );

   // ctl = {branch, reg_write, mem_to_reg, mem_write, mem_read}
   typedef struct {
      logic [31:0] npc, d1, d2, imm;
      logic [1:0]  op;
      logic        src, dst;
      logic [4:0]  ctl, rs, rt, rd, wb_rd;
      logic        wb_we;
      logic [31:0] wb_dat;
      logic [31:0] e_res;
      logic        e_zero;
      logic [4:0]  e_rd;
      logic [31:0] e_wd, e_tgt;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;

   // What the bench believes EX/MEM currently holds, for forwarding.
   logic [31:0] m_prev_res = '0;
   logic [4:0]  m_prev_rd = '0;
   logic        m_prev_rw = 1'b0;
   logic        m_prev_mr = 1'b0;

   function automatic vec_t mkv(input logic [31:0] npc, vd1, vd2, vimm, input logic [1:0] op,
                                input logic src, dst, input logic [4:0] ctl, rs, rt, rd, wb_rd,
                                input logic wb_we, input logic [31:0] wb_dat, e_res,
                                input logic e_zero, input logic [4:0] e_rd,
                                input logic [31:0] e_wd, e_tgt);
      vec_t v;
      v.npc = npc; v.d1 = vd1; v.d2 = vd2; v.imm = vimm; v.op = op; v.src = src; v.dst = dst;
      v.ctl = ctl; v.rs = rs; v.rt = rt; v.rd = rd; v.wb_rd = wb_rd; v.wb_we = wb_we;
      v.wb_dat = wb_dat; v.e_res = e_res; v.e_zero = e_zero; v.e_rd = e_rd;
      v.e_wd = e_wd; v.e_tgt = e_tgt;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      nextpc = v.npc; d1 = v.d1; d2 = v.d2; imm = v.imm; alu_op_i = v.op;
      alu_src_i = v.src; reg_dst_i = v.dst;
      {branch_i, reg_write_i, mem_to_reg_i, mem_write_i, mem_read_i} = v.ctl;
      rs_i = v.rs; rt_i = v.rt; rd_i = v.rd;
      rd_wb = v.wb_rd; reg_write_wb = v.wb_we; reg_wr_data = v.wb_dat;
   endtask

   task automatic tick();
      @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [4:0] ctl_out();
      return {branch_o, reg_write_o, mem_to_reg_o, mem_write_o, mem_read_o};
   endfunction

   task automatic check_vec(input string tag, input vec_t v);
      chk({tag, "_result"}, alu_result, v.e_res);
      chk({tag, "_zero"},   {31'd0, zero_o}, {31'd0, v.e_zero});
      chk({tag, "_rd"},     {27'd0, rd_o}, {27'd0, v.e_rd});
      chk({tag, "_wrdata"}, wr_data, v.e_wd);
      chk({tag, "_target"}, target, v.e_tgt);
      chk({tag, "_ctl"},    {27'd0, ctl_out()}, {27'd0, v.ctl});
      m_prev_res = v.e_res; m_prev_rd = v.e_rd; m_prev_rw = v.ctl[3]; m_prev_mr = v.ctl[0];
   endtask

   function automatic logic [31:0] pick(input logic [4:0] r, input logic [31:0] id_val, input vec_t v);
      if (r != 5'd0 && m_prev_rw && !m_prev_mr && m_prev_rd == r) return m_prev_res;
      if (r != 5'd0 && v.wb_we && v.wb_rd == r) return v.wb_dat;
      return id_val;
   endfunction

   function automatic vec_t predict(input vec_t v);
      vec_t r;
      logic [31:0] a, rt_val, b;
      r = v;
      a = pick(v.rs, v.d1, v);
      rt_val = pick(v.rt, v.d2, v);
      b = v.src ? v.imm : rt_val;
      case (v.op)
         2'd0: r.e_res = a + b;
         2'd1: r.e_res = a - b;
         2'd3: r.e_res = a | (v.imm & 32'h0000FFFF);
         default: begin
            case (v.imm[5:0])
               6'h20:   r.e_res = a + b;
               6'h22:   r.e_res = a - b;
               6'h24:   r.e_res = a & b;
               6'h25:   r.e_res = a | b;
               6'h2A:   r.e_res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
               6'h00:   r.e_res = b << v.imm[10:6];
               default: r.e_res = 32'd0;
            endcase
         end
      endcase
      r.e_zero = (r.e_res == 32'd0);
      r.e_rd = v.dst ? v.rd : v.rt;
      r.e_wd = rt_val;
      r.e_tgt = v.npc + v.imm * 4;
      return r;
   endfunction

   function automatic vec_t rand_vec();
      vec_t v;
      logic [5:0] fl [7];
      fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h3F};
      v = mkv(0, 0, 0, 0, 2'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      v.npc = $urandom; v.d1 = $urandom; v.d2 = $urandom; v.imm = $urandom;
      if ($urandom_range(0, 3) == 0) v.d2 = v.d1;
      v.op = 2'($urandom_range(0, 3));
      if (v.op == 2'd2) v.imm[5:0] = fl[$urandom_range(0, 6)];
      v.src = 1'($urandom); v.dst = 1'($urandom); v.ctl = 5'($urandom);
      v.rs = 5'($urandom_range(0, 3)); v.rt = 5'($urandom_range(0, 3)); v.rd = 5'($urandom_range(0, 3));
      v.wb_rd = 5'($urandom_range(0, 3)); v.wb_we = 1'($urandom); v.wb_dat = $urandom;
      return v;
   endfunction

`ifdef EX_MUL_EN
   task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv);
      int stall_cyc = 0;
      int edges = 0;
      int bubble_bad = 0;
      drive(mkv(32'h40, a, b, 32'h18, 2'd2, 0, 1, 5'b01000, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0));
      #1;
      while (stall_ex && edges < 100) begin
         stall_cyc++;
         tick();
         edges++;
         if (ctl_out() != 5'd0) bubble_bad++;
      end
      tick();
      edges++;
      chk({tag, "_stall_cycles"}, stall_cyc, 33);
      chk({tag, "_bubbles"}, bubble_bad, 0);
      chk({tag, "_latency"}, edges, 34);
      chk({tag, "_result"}, alu_result, expv);
      chk({tag, "_ctl"}, {27'd0, ctl_out()}, {27'd0, 5'b01000});
      chk({tag, "_rd"}, {27'd0, rd_o}, 32'd3);
      chk({tag, "_target"}, target, 32'h40 + 32'h60);
      m_prev_res = expv; m_prev_rd = 5'd3; m_prev_rw = 1'b1; m_prev_mr = 1'b0;
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[$];
      vec_t v;
      vec_t nop;
      nop = mkv(0, 0, 0, 0, 2'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      reset = 1'b0;
      drive(nop);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_result", alu_result, 0);
      chk("rst_wrdata", wr_data, 0);
      chk("rst_target", target, 0);
      chk("rst_rd_zero_ctl", {25'd0, rd_o, zero_o, ctl_out()}, 0);
      chk("rst_stall", {31'd0, stall_ex}, 0);
      reset = 1'b1;

      //                 npc     d1            d2        imm            op    s  d  ctl       rs  rt  rd  wrd we wdat  res           z  erd  ewd     etgt
      tbl.push_back(mkv(0,      5,            7,        'h20,          2'd2, 0, 1, 5'b01000, 1,  2,  3,  0,  0, 0,    12,           0, 3,   7,      'h80));
      tbl.push_back(mkv(0,      1,            2,        'h20,          2'd2, 0, 1, 5'b01000, 1,  2,  3,  0,  0, 0,    3,            0, 3,   2,      'h80));
      tbl.push_back(mkv(0,      'hAAAA,       'h5555,   'h22,          2'd2, 0, 1, 5'b01000, 3,  3,  4,  3,  1, 99,   0,            1, 4,   3,      'h88));
      tbl.push_back(mkv(0,      'h1111,       5,        'h20,          2'd2, 0, 1, 5'b01000, 4,  7,  6,  4,  1, 77,   5,            0, 6,   5,      'h80));
      tbl.push_back(mkv(0,      1,            2,        'h20,          2'd2, 0, 1, 5'b01000, 9,  6,  8,  9,  1, 1000, 1005,         0, 8,   5,      'h80));
      tbl.push_back(mkv(0,      'h200,        'h33,     'h10,          2'd0, 1, 0, 5'b01101, 1,  10, 0,  0,  0, 0,    'h210,        0, 10,  'h33,   'h40));
      tbl.push_back(mkv(0,      7,            3,        'h20,          2'd2, 0, 1, 5'b01000, 10, 11, 12, 0,  0, 0,    'hA,          0, 12,  3,      'h80));
      tbl.push_back(mkv('h100,  'h55,         'h55,     'hFFFFFFFC,    2'd1, 0, 0, 5'b10000, 13, 14, 0,  0,  0, 0,    0,            1, 14,  'h55,   'hF0));
      tbl.push_back(mkv(0,      'hFFFFFFFF,   1,        'h2A,          2'd2, 0, 1, 5'b01000, 1,  2,  5,  0,  0, 0,    1,            0, 5,   1,      'hA8));
      tbl.push_back(mkv(0,      'h1234,       1,        'h7C0,         2'd2, 0, 1, 5'b01000, 1,  2,  6,  0,  0, 0,    'h80000000,   0, 6,   1,      'h1F00));
      tbl.push_back(mkv(0,      'hF0,         9,        'h8000FFFF,    2'd3, 1, 0, 5'b01000, 1,  7,  0,  0,  0, 0,    'hFFFF,       0, 7,   9,      'h3FFFC));
      tbl.push_back(mkv(0,      'hF0F0,       'h0FF0,   'h24,          2'd2, 0, 1, 5'b01000, 1,  2,  3,  0,  0, 0,    'hF0,         0, 3,   'hFF0,  'h90));
      tbl.push_back(mkv(0,      'hF000,       'hF,      'h25,          2'd2, 0, 1, 5'b01000, 1,  2,  3,  0,  0, 0,    'hF00F,       0, 3,   'hF,    'h94));
      tbl.push_back(mkv(0,      5,            6,        'h3F,          2'd2, 0, 1, 5'b01000, 1,  2,  3,  0,  0, 0,    0,            1, 3,   6,      'hFC));
      tbl.push_back(mkv(0,      'h100,        'hDEAD,   4,             2'd0, 1, 0, 5'b00010, 1,  2,  0,  0,  0, 0,    'h104,        0, 2,   'hDEAD, 'h10));
      tbl.push_back(mkv(0,      3,            4,        'h20,          2'd2, 0, 1, 5'b01000, 1,  2,  0,  0,  0, 0,    7,            0, 0,   4,      'h80));
      tbl.push_back(mkv(0,      0,            0,        'h20,          2'd2, 0, 1, 5'b01000, 0,  0,  1,  0,  1, 'h55, 0,            1, 1,   0,      'h80));
      tbl.push_back(mkv(0,      4,            4,        0,             2'd1, 0, 0, 5'b10000, 2,  5,  9,  2,  0, 9,    0,            1, 5,   4,      0));

      foreach (tbl[i]) begin
         drive(tbl[i]);
         tick();
         check_vec($sformatf("vec%0d", i), tbl[i]);
      end

      for (int i = 0; i < 200; i++) begin
         v = predict(rand_vec());
         drive(v);
         tick();
         check_vec($sformatf("rnd%0d", i), v);
      end

      // Reset asserted between edges with live state in EX/MEM.
      drive(nop);
      reset = 1'b0;
      #1;
      chk("midrst_result", alu_result, 0);
      chk("midrst_wrdata_target", wr_data | target, 0);
      chk("midrst_rd_zero_ctl", {25'd0, rd_o, zero_o, ctl_out()}, 0);
      chk("midrst_stall", {31'd0, stall_ex}, 0);
      tick();
      tick();
      reset = 1'b1;
      m_prev_res = '0; m_prev_rd = '0; m_prev_rw = 1'b0; m_prev_mr = 1'b0;
      v = mkv(0, 5, 7, 'h20, 2'd2, 0, 1, 5'b01000, 1, 2, 3, 0, 0, 0, 12, 0, 3, 7, 'h80);
      drive(v);
      tick();
      check_vec("post_rst_add", v);

`ifdef EX_MUL_EN
      run_mul("mul_a", 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF);
      run_mul("mul_b2b", 32'd3, 32'd5, 32'd15);
      run_mul("mul_wrap", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1);
      drive(nop);
      tick();
      begin
         int hits = 0;
         drive(mkv(0, 32'h0000FFFF, 32'h00010001, 32'h18, 2'd2, 0, 1, 5'b01000, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0));
         repeat (11) tick();
         drive(nop);
         reset = 1'b0;
         #1;
         chk("mulrst_stall", {31'd0, stall_ex}, 0);
         chk("mulrst_ctl", {27'd0, ctl_out()}, 0);
         tick();
         reset = 1'b1;
         for (int k = 0; k < 40; k++) begin
            tick();
            if (reg_write_o || alu_result == 32'hFFFFFFFF || stall_ex) hits++;
         end
         chk("mulrst_no_commit", hits, 0);
      end
`else
      drive(mkv(0, 32'h0000FFFF, 32'h00010001, 32'h18, 2'd2, 0, 1, 5'b01000, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0));
      #1;
      chk("nomul_stall", {31'd0, stall_ex}, 0);
      tick();
      chk("nomul_result", alu_result, 0);
      chk("nomul_zero", {31'd0, zero_o}, 1);
      chk("nomul_ctl", {27'd0, ctl_out()}, {27'd0, 5'b01000});
      chk("nomul_stall_after", {31'd0, stall_ex}, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute stage plus EX/MEM pipeline register of the 5-stage MIPS-style pipeline. It consumes the ID/EX register outputs, resolves operand forwarding from EX/MEM and MEM/WB, and computes the ALU result, the destination register and the branch target. Results are registered into the EX/MEM outputs consumed by the memory stage. An optional iterative multiplier stalls the front of the pipeline while it runs.

## Interface
Parameters:
- `MUL_CYCLES`, default 32: number of shift-add iterations. Must be 32 for full 32×32 low-word multiply.

Ports:
- `clk`  in  1  pipeline clock. All registers update on the falling edge, matching neighbouring pipeline registers.
- `reset`  in  1  asynchronous, active-low reset.
- `nextpc`, `reg_file_out_data1`, `reg_file_out_data2`, `sgn_ext_imm_out`  in  32 each  from ID/EX.
- `branch_out_id_ex`, `reg_write_out_id_ex`, `mem_to_reg_out_id_ex`, `mem_write_out_id_ex`, `mem_read_out_id_ex`, `alu_src_out_id_ex`, `reg_dst_id_ex`  in  1 each  ID/EX controls.
- `alu_op_out_id_ex`  in  2  ALU class.
- `inst_read_reg_addr1_out_id_ex`, `inst_read_reg_addr2_out_id_ex`, `rd_out_id_ex`  in  5 each  rs, rt, rd.
- `rd_out_wb`  in  5  MEM/WB destination.
- `reg_write_out_wb`  in  1  MEM/WB write enable.
- `reg_wr_data`  in  32  MEM/WB write-back data.
- `alu_result_out_ex_mem`, `wr_data_out_ex_mem`, `branch_target_out_ex_mem`  out  32 each.
- `rd_out_ex_mem`  out  5  selected destination.
- `zero_out_ex_mem`, `branch_out_ex_mem`, `reg_write_out_ex_mem`, `mem_to_reg_out_ex_mem`, `mem_write_out_ex_mem`, `mem_read_out_ex_mem`  out  1 each.
- `stall_ex`  out  1  combinational. Holds PC, IF/ID and ID/EX while high.

## Operation
- **Forwarding of operand A (rs) and raw B (rt):**
  - Priority 1: EX/MEM when `reg_write_out_ex_mem`, `rd_out_ex_mem`≠0, `mem_read_out_ex_mem`=0, and the rd matches. Uses `alu_result_out_ex_mem`.
  - Priority 2: MEM/WB when `reg_write_out_wb`, `rd_out_wb`≠0, and the rd matches. Uses `reg_wr_data`.
  - Otherwise: the ID/EX data.
  - Load-use is handled by the hazard unit, not here.
- **Operand B:** `alu_src` ? `sgn_ext_imm` : forwarded rt.
- **Store data:** `wr_data_out_ex_mem` always takes the forwarded rt.
- **ALU op select:**
  - `alu_op` 00: add.
  - `alu_op` 01: sub.
  - `alu_op` 11: A OR zero-extended imm[15:0].
  - `alu_op` 10: decode funct = imm[5:0]:
    - 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A signed slt (result 0/1).
    - 0x00 sll B by imm[10:6].
    - 0x18 multiply (low 32 bits).
    - Any other funct gives 0.
- **Flags and targets:**
  - Add and sub wrap modulo 2^32; no overflow trap.
  - `zero` = (result==0).
  - Branch target = `nextpc` + (imm<<2), modulo 2^32.
- **Destination:** `reg_dst` ? rd : rt.
- **Multiplier FSM:**
  - States: IDLE → BUSY → DONE → IDLE.
  - IDLE, multiply present: latch A, B and the controls; counter=0; go BUSY.
  - BUSY: one shift-add per edge. Go DONE when counter=`MUL_CYCLES`−1.
  - DONE: commit the product with the latched controls; go IDLE.
  - `stall_ex` = multiply present in ID/EX and state≠DONE.
- **Pipeline register behaviour:**
  - While `stall_ex` is high, EX/MEM outputs load a bubble: all control outputs 0, data don't-care (held).
  - Non-multiply instructions pass in one edge.

## Timing
- All outputs are 0 on reset. The FSM resets to IDLE with counter 0.
- Non-multiply latency: 1 falling edge from ID/EX to EX/MEM.
- Multiply: `stall_ex` is high for `MUL_CYCLES`+1 cycles. The result appears in EX/MEM `MUL_CYCLES`+2 edges after ID/EX presents it.
- Back-to-back multiplies: the second starts in the IDLE edge following commit.
- Forwarding is combinational within the cycle. During a multiply, forwarded operands are captured at the IDLE→BUSY edge only.
- Reset asserted mid-multiply: the FSM aborts to IDLE immediately, `stall_ex` drops, and no result is committed.
- Products wrap; only bits [31:0] are kept.

## Configuration
- `EX_MUL_EN` defined: the multiplier FSM and funct 0x18 are supported as above.
- `EX_MUL_EN` undefined:
  - No FSM is built and `stall_ex` is tied to 0.
  - Funct 0x18 is treated as unknown: result 0, zero=1.
  - Controls pass through in one edge.

## Test plan
- Reset low mid-run → all outputs 0, `stall_ex`=0. After release, add 5+7 with `alu_op`=10, funct 0x20 → result 12, zero 0, one edge later.
- Dependent chain: add r3=1+2, then sub r4=r3−r3, with r3 forwarded from EX/MEM → result 0, zero=1. The same rd pending in both EX/MEM and WB selects EX/MEM.
- Branch: `nextpc`=0x100, imm=−4, `alu_op`=01, operands equal → target 0xF0, zero=1, branch=1.
- slt −1 vs 1 → 1. sll 0x1 by 31 → 0x80000000. ori 0xF0 | 0x8000FFFF imm → zero-extended to 0x0000FFFF, so result = A|0xFFFF.
- With `EX_MUL_EN`: multiply 0xFFFF × 0x10001 → 0xFFFFFFFF. `stall_ex` is high 33 cycles, with bubbles carrying zero controls. Reset at BUSY cycle 10 → no commit.
- Without `EX_MUL_EN`: funct 0x18 → result 0, `stall_ex` never asserts.
